// File: rtl/layer_seq_ctrl.sv
// Layer sequencer for a time-shared fully-connected neuron: fetch row, settle, capture, hand off.
// Optional argmax tracker on accepted results is enabled by defining LAYER_SEQ_ARGMAX_EN.
module layer_seq_ctrl #(
    parameter int unsigned N_OUT_MAX = 16,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DW        = 32,
    parameter int unsigned SETTLE    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] cfg_nout,
    input  logic              cfg_relu,
    output logic              busy,
    output logic              done,
    output logic              w_rd,
    output logic [ADDR_W-1:0] w_addr,
    output logic              w_load,
    output logic              neuron_relu,
    input  logic [DW-1:0]     neuron_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ADDR_W-1:0] res_addr,
    output logic [DW-1:0]     res_data,
    output logic [ADDR_W-1:0] max_idx
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_SETTLE,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_idx, w_idx_nx;
    logic [ADDR_W-1:0] r_nout, w_nout_nx;
    logic              r_relu, w_relu_nx;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nx;
    logic              w_cap, w_start, w_hs, w_busy_nx;

    logic              r_busy, r_done, r_w_rd, r_w_load, r_neuron_relu, r_res_valid;
    logic [ADDR_W-1:0] r_w_addr, r_res_addr;
    logic [DW-1:0]     r_res_data;

    assign w_hs      = r_res_valid & res_ready;
    assign w_busy_nx = (w_state_nx != S_IDLE) && (w_state_nx != S_DONE);

    // Next-state and datapath-register decode
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_nout_nx  = r_nout;
        w_relu_nx  = r_relu;
        w_cnt_nx   = r_cnt;
        w_cap      = 1'b0;
        w_start    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start    = 1'b1;
                    w_nout_nx  = (cfg_nout > ADDR_W'(N_OUT_MAX)) ? ADDR_W'(N_OUT_MAX) : cfg_nout;
                    w_relu_nx  = cfg_relu;
                    w_idx_nx   = '0;
                    w_state_nx = (cfg_nout != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: w_state_nx = S_WAIT;
            S_WAIT: begin
                w_cnt_nx   = '0;
                w_state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == CNT_W'(SETTLE - 1)) begin
                    w_cap      = 1'b1;
                    w_state_nx = S_WRITE;
                end else begin
                    w_cnt_nx = r_cnt + CNT_W'(1);
                end
            end
            S_WRITE: begin
                if (w_hs) begin
                    if (r_idx == (r_nout - ADDR_W'(1))) begin
                        w_state_nx = S_DONE;
                    end else begin
                        w_idx_nx   = r_idx + ADDR_W'(1);
                        w_state_nx = S_FETCH;
                    end
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they align with the state they describe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idx         <= '0;
            r_nout        <= '0;
            r_relu        <= 1'b0;
            r_cnt         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_w_rd        <= 1'b0;
            r_w_load      <= 1'b0;
            r_neuron_relu <= 1'b0;
            r_res_valid   <= 1'b0;
            r_w_addr      <= '0;
            r_res_addr    <= '0;
            r_res_data    <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_idx         <= w_idx_nx;
            r_nout        <= w_nout_nx;
            r_relu        <= w_relu_nx;
            r_cnt         <= w_cnt_nx;
            r_busy        <= w_busy_nx;
            r_done        <= (w_state_nx == S_DONE);
            r_w_rd        <= (w_state_nx == S_FETCH);
            r_w_load      <= (w_state_nx == S_WAIT);
            r_res_valid   <= (w_state_nx == S_WRITE);
            r_neuron_relu <= w_busy_nx & w_relu_nx;
            if (w_state_nx == S_FETCH) begin
                r_w_addr <= w_idx_nx;
            end
            if (w_cap) begin
                r_res_data <= neuron_out;
                r_res_addr <= r_idx;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign w_rd        = r_w_rd;
    assign w_load      = r_w_load;
    assign w_addr      = r_w_addr;
    assign neuron_relu = r_neuron_relu;
    assign res_valid   = r_res_valid;
    assign res_addr    = r_res_addr;
    assign res_data    = r_res_data;

`ifdef LAYER_SEQ_ARGMAX_EN
    localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW - 1){1'b0}}};

    logic signed [DW-1:0] r_max_val;
    logic [ADDR_W-1:0]    r_max_idx;

    // Sign-magnitude to two's complement; -0 and +0 both map to zero
    function automatic logic signed [DW-1:0] sm_val(input logic [DW-1:0] v);
        logic signed [DW-1:0] mag;
        mag = $signed({1'b0, v[DW-2:0]});
        return v[DW-1] ? -mag : mag;
    endfunction

    // Strictly-greater replace keeps the lowest index on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_max_val <= MOST_NEG;
            r_max_idx <= '0;
        end else if (w_start) begin
            r_max_val <= MOST_NEG;
            r_max_idx <= '0;
        end else if (w_hs && (sm_val(r_res_data) > r_max_val)) begin
            r_max_val <= sm_val(r_res_data);
            r_max_idx <= r_res_addr;
        end
    end

    assign max_idx = r_max_idx;
`else
    assign max_idx = '0;
`endif

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Scoreboard bench for layer_seq_ctrl: directed layers, expected results queued, monitor compares handshakes.
module tb_layer_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  cfg_nout;
    logic        cfg_relu;
    logic        busy, done, w_rd, w_load, neuron_relu, res_valid, res_ready;
    logic [7:0]  w_addr, res_addr, max_idx;
    logic [31:0] neuron_out, res_data;

    layer_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_nout(cfg_nout), .cfg_relu(cfg_relu),
        .busy(busy), .done(done), .w_rd(w_rd), .w_addr(w_addr), .w_load(w_load),
        .neuron_relu(neuron_relu), .neuron_out(neuron_out), .res_valid(res_valid),
        .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data), .max_idx(max_idx)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; logic [31:0] data; int c; } exp_t;
    typedef struct { int c; int a; } rd_t;

    exp_t        sb[$];
    rd_t         rd_q[$];
    logic [31:0] vals[16];
    logic [7:0]  row_q = 8'd0;
    int          cyc = 0;
    int          t0 = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    int          busy_seen, relu_bad, mx_bad;
    int          d;
    logic [31:0] bp_data;

    // Neuron model: row registered on w_load, output is that row's table value
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (w_load) row_q <= w_addr;
    end
    assign neuron_out = vals[row_q[3:0]];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc - t0);
    endtask

    function automatic int exp_mx(input int v);
`ifdef LAYER_SEQ_ARGMAX_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    // Monitor: every accepted result is matched against the head of the scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("res_addr", 64'(res_addr), 64'(e.addr));
                chk("res_data", 64'(res_data), 64'(e.data));
                chk("res_cycle", 64'(cyc - t0), 64'(e.c));
            end
        end
    end

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input logic [31:0] dt, input int c);
        exp_t e;
        e.addr = a; e.data = dt; e.c = c;
        sb.push_back(e);
    endtask

    task automatic start_layer(input int n, input logic relu);
        drv();
        cfg_nout = 8'(n);
        cfg_relu = relu;
        start    = 1'b1;
        t0       = cyc;
        drv();
        start    = 1'b0;
    endtask

    task automatic wait_done(input int budget, input logic exp_relu, output int dc);
        dc = -1;
        rd_q.delete();
        busy_seen = 0;
        relu_bad  = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (w_rd) rd_q.push_back('{cyc - t0, int'(w_addr)});
            if (busy) busy_seen = 1;
            if (neuron_relu !== (busy & exp_relu)) relu_bad++;
`ifndef LAYER_SEQ_ARGMAX_EN
            if (max_idx != 8'd0) mx_bad++;
`endif
            if (done) begin
                dc = cyc - t0;
                chk("busy_at_done", 64'(busy), 64'd0);
                break;
            end
        end
        if (dc < 0) chk("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic set_ramp();
        for (int i = 0; i < 16; i++) vals[i] = 32'(i + 5);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; start = 1'b0; cfg_nout = 8'd0; cfg_relu = 1'b0; res_ready = 1'b1;
        mx_bad = 0;
        set_ramp();
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_w_rd", 64'(w_rd), 64'd0);
        chk("rst_w_load", 64'(w_load), 64'd0);
        chk("rst_relu", 64'(neuron_relu), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_w_addr", 64'(w_addr), 64'd0);
        chk("rst_res_addr", 64'(res_addr), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_max_idx", 64'(max_idx), 64'd0);
        drv();
        rst = 1'b0;

        // Nominal: three neurons, results every five cycles
        push(0, 32'd5, 5); push(1, 32'd6, 10); push(2, 32'd7, 15);
        start_layer(3, 1'b0);
        wait_done(60, 1'b0, d);
        chk("nom_done_cyc", 64'(d), 64'd16);
        chk("nom_rd_count", 64'(rd_q.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < rd_q.size()) begin
                chk("nom_rd_cyc", 64'(rd_q[i].c), 64'(1 + 5 * i));
                chk("nom_rd_addr", 64'(rd_q[i].a), 64'(i));
            end
        end
        chk("nom_max_idx", 64'(max_idx), 64'(exp_mx(2)));
        chk("nom_sb_empty", 64'(sb.size()), 64'd0);

        // Zero-neuron layer
        start_layer(0, 1'b0);
        wait_done(10, 1'b0, d);
        chk("zero_done_cyc", 64'(d), 64'd1);
        chk("zero_no_rd", 64'(rd_q.size()), 64'd0);
        chk("zero_no_busy", 64'(busy_seen), 64'd0);

        // Start pulsed mid-layer with different config is ignored
        push(0, 32'd5, 5); push(1, 32'd6, 10); push(2, 32'd7, 15);
        start_layer(3, 1'b0);
        drv(); drv();
        start = 1'b1; cfg_nout = 8'd1; cfg_relu = 1'b1;
        drv();
        start = 1'b0;
        wait_done(60, 1'b0, d);
        chk("ign_done_cyc", 64'(d), 64'd16);
        chk("ign_rd_count", 64'(rd_q.size()), 64'd2);
        for (int i = 0; i < 2; i++) begin
            if (i < rd_q.size()) begin
                chk("ign_rd_cyc", 64'(rd_q[i].c), 64'(6 + 5 * i));
                chk("ign_rd_addr", 64'(rd_q[i].a), 64'(i + 1));
            end
        end
        chk("ign_relu_bad", 64'(relu_bad), 64'd0);

        // ReLU latched at start, config dropped afterwards
        push(0, 32'd5, 5); push(1, 32'd6, 10);
        start_layer(2, 1'b1);
        cfg_relu = 1'b0;
        wait_done(40, 1'b1, d);
        chk("relu_done_cyc", 64'(d), 64'd11);
        chk("relu_busy_seen", 64'(busy_seen), 64'd1);
        chk("relu_bad_cycles", 64'(relu_bad), 64'd0);
        chk("relu_at_done", 64'(neuron_relu), 64'd0);
        @(negedge clk);
        chk("relu_idle", 64'(neuron_relu), 64'd0);

        // Backpressure: first result held for four cycles
        vals[0] = 32'h8000_0011; vals[1] = 32'h0000_0022;
        bp_data = 32'h8000_0011;
        res_ready = 1'b0;
        start_layer(2, 1'b0);
        d = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (res_valid) begin d = cyc - t0; break; end
        end
        chk("bp_first_cyc", 64'(d), 64'd5);
        chk("bp_addr_0", 64'(res_addr), 64'd0);
        chk("bp_data_0", 64'(res_data), 64'(bp_data));
        for (int j = 1; j < 4; j++) begin
            @(negedge clk);
            chk("bp_valid_hold", 64'(res_valid), 64'd1);
            chk("bp_addr_hold", 64'(res_addr), 64'd0);
            chk("bp_data_hold", 64'(res_data), 64'(bp_data));
        end
        push(0, 32'h8000_0011, 9); push(1, 32'h0000_0022, 14);
        drv();
        res_ready = 1'b1;
        wait_done(40, 1'b0, d);
        chk("bp_done_cyc", 64'(d), 64'd15);
        chk("bp_max_idx", 64'(max_idx), 64'(exp_mx(1)));
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset in SETTLE of neuron 1, then a clean four-neuron layer
        set_ramp();
        push(0, 32'd5, 5);
        start_layer(4, 1'b0);
        repeat (7) drv();
        rst = 1'b1;
        #1;
        chk("mid_rst_outs", {2'b0, busy, done, w_rd, w_load, neuron_relu, res_valid,
                             w_addr, res_addr, res_data, max_idx}, 64'd0);
        @(negedge clk);
        chk("mid_rst_no_done", 64'(done), 64'd0);
        drv();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_sb", 64'(sb.size()), 64'd0);
        push(0, 32'd5, 5); push(1, 32'd6, 10); push(2, 32'd7, 15); push(3, 32'd8, 20);
        start_layer(4, 1'b0);
        wait_done(80, 1'b0, d);
        chk("rerun_done_cyc", 64'(d), 64'd21);
        chk("rerun_max_idx", 64'(max_idx), 64'(exp_mx(3)));

        // Argmax: +3, -9, +7, +7 -> index 2
        vals[0] = 32'h0000_0003; vals[1] = 32'h8000_0009;
        vals[2] = 32'h0000_0007; vals[3] = 32'h0000_0007;
        push(0, 32'h0000_0003, 5); push(1, 32'h8000_0009, 10);
        push(2, 32'h0000_0007, 15); push(3, 32'h0000_0007, 20);
        start_layer(4, 1'b0);
        wait_done(80, 1'b0, d);
        chk("amax_done_cyc", 64'(d), 64'd21);
        chk("amax_max_idx", 64'(max_idx), 64'(exp_mx(2)));

        // +0 then -0 compare equal, lower index kept
        vals[0] = 32'h0000_0000; vals[1] = 32'h8000_0000;
        push(0, 32'h0000_0000, 5); push(1, 32'h8000_0000, 10);
        start_layer(2, 1'b0);
        wait_done(40, 1'b0, d);
        chk("zero_tie_done", 64'(d), 64'd11);
        chk("zero_tie_max", 64'(max_idx), 64'(exp_mx(0)));
        chk("final_sb_empty", 64'(sb.size()), 64'd0);
`ifndef LAYER_SEQ_ARGMAX_EN
        chk("max_idx_tied", 64'(mx_bad), 64'd0);
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/layer_seq_ctrl.md
# layer_seq_ctrl

Sequencer for one time-shared 32-input fully-connected neuron datapath: it walks a layer's output neurons one at a time, fetches each neuron's weight/bias row from weight memory, waits out the combinational MAC settle time, captures the sign-magnitude result and hands it downstream on a valid/ready port. It sits between the layer-level control (start/done), the weight ROM, the neuron datapath and the activation buffer of the next layer.

## Interface
- N_OUT_MAX, 16: largest supported number of output neurons per layer.
- ADDR_W, 8: weight-row address width; must satisfy 2^ADDR_W >= N_OUT_MAX.
- DW, 32: neuron result width (sign-magnitude, bit DW-1 = sign).
- SETTLE, 2: cycles allowed for the combinational neuron to settle; legal range 1..15.

- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begin a layer; sampled only in IDLE.
- cfg_nout  in  ADDR_W  neuron count for this layer, latched at start; legal 0..N_OUT_MAX.
- cfg_relu  in  1  ReLU enable, latched at start.
- busy  out  1  high from the cycle after start until the last result handshake.
- done  out  1  one-cycle pulse at layer completion.
- w_rd  out  1  weight-row read strobe.
- w_addr  out  ADDR_W  weight-row address = current neuron index.
- w_load  out  1  datapath weight/bias register load strobe (memory read latency is 1).
- neuron_relu  out  1  drives the neuron's relu input; equals latched cfg_relu while busy, else 0.
- neuron_out  in  DW  neuron result.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_addr  out  ADDR_W  index of the result being offered.
- res_data  out  DW  registered result.
- max_idx  out  ADDR_W  index of largest result (see Configuration).

## Operation
- States: IDLE, FETCH, WAIT, SETTLE, WRITE, DONE.
- IDLE: start=1 -> latch cfg_nout/cfg_relu, idx=0; to FETCH if cfg_nout!=0, else to DONE (zero-neuron layer, no reads, no results).
- FETCH: w_rd=1, w_addr=idx; -> WAIT.
- WAIT: w_load=1 (row data valid this cycle); settle counter cleared; -> SETTLE.
- SETTLE: count SETTLE cycles; on the edge leaving the last one, res_data <= neuron_out, res_addr <= idx; -> WRITE.
- WRITE: res_valid=1, res_data/res_addr held stable until res_valid&res_ready; on handshake: idx==nout-1 -> DONE, else idx+1 -> FETCH.
- DONE: done=1, busy=0; -> IDLE.
- start outside IDLE is ignored; cfg_* changes after start have no effect.
- w_addr holds its last value outside FETCH; w_rd/w_load are single-cycle strobes.
- rst at any time: state IDLE immediately, in-flight result dropped, no done pulse.

## Timing
- Reset values: busy, done, w_rd, w_load, neuron_relu, res_valid = 0; w_addr, res_addr, res_data, max_idx = 0.
- start sampled at cycle 0 -> FETCH cycle 1, WAIT cycle 2, SETTLE cycles 3..2+SETTLE, first res_valid cycle 3+SETTLE.
- Per-neuron period with res_ready held high: 3+SETTLE cycles; layer: nout*(3+SETTLE) cycles from start to last handshake, done the following cycle.
- Backpressure: each cycle of res_ready=0 in WRITE adds one cycle; nothing else stalls.
- cfg_nout=0: done in cycle 1, busy never asserted.

## Configuration
- LAYER_SEQ_ARGMAX_EN defined: tracker compares each accepted result (sign-magnitude signed compare; +0 and -0 equal) against running max; strictly greater replaces it, ties keep lower index; cleared to idx 0 / most-negative at start; max_idx updated on each handshake, valid at done, held until next start.
- Undefined: no tracker logic; max_idx tied to 0.

## Test plan
- Reset mid-layer: cfg_nout=4, assert rst in SETTLE of neuron 1 -> all outputs 0 next cycle, no done, fresh start runs 4 full results.
- Nominal: SETTLE=2, cfg_nout=3, res_ready=1, neuron_out model = idx+5 -> results (0,5),(1,6),(2,7) at cycles 5, 10, 15; done at cycle 16; w_addr 0,1,2 at cycles 1, 6, 11.
- Backpressure: cfg_nout=2, res_ready low 4 cycles in first WRITE -> res_data/res_addr stable throughout, second result 4 cycles late, exactly 2 handshakes.
- Zero layer and ignored start: cfg_nout=0 -> done at cycle 1, no w_rd/res_valid; start pulsed while busy -> no restart, idx sequence unchanged.
- ReLU and latch: cfg_relu=1 at start then driven 0 -> neuron_relu stays 1 until done, 0 in IDLE.
- Argmax (macro on): results +3, -9, +7, +7 (sign-magnitude) -> max_idx=2 at done; macro off -> max_idx=0 throughout.
